// File: rtl/load_store_unit_if.sv
// Request/response bus between the MEM stage (master) and the load/store unit (slave).
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word requests into word-only memory
// accesses. Sub-word stores are done as a two-cycle read-modify-write.
module load_store_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  load_store_unit_if.slave      bus,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [31:0]           Write_data,
  input  logic [31:0]           Read_data
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] rmw_addr;
  logic [31:0]           rmw_word;
  logic [15:0]           rmw_wdata;
  logic [1:0]            rmw_lane;
  logic                  rmw_half;

  logic                  accept;
  logic                  err;
  logic                  go;
  logic                  rmw_active;
  logic [ADDR_WIDTH-1:0] aligned_addr;

  // Pick the addressed lane out of a word and extend it.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] size,
                                          input logic [1:0] lane, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {lane, 3'b000});
    h = lane[1] ? w[31:16] : w[15:0];
    case (size)
      2'd0:    return {{24{sgn & b[7]}}, b};
      2'd1:    return {{16{sgn & h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // Replace only the target byte/half lane of the previously read word.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [15:0] d,
                                        input logic [1:0] lane, input logic half);
    logic [31:0] mask;
    logic [31:0] data;
    logic [4:0]  sh;
    sh   = half ? {lane[1], 4'b0000} : {lane, 3'b000};
    mask = (half ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
    data = (half ? {16'h0000, d} : {24'h000000, d[7:0]}) << sh;
    return (w & ~mask) | (data & mask);
  endfunction

  assign bus.req_ready = (state == IDLE);
  assign accept        = bus.req_valid && (state == IDLE) && !reset;
  assign aligned_addr  = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
  assign go            = accept && !err;
  // A reset arriving during RMW_WR must suppress the pending write this cycle.
  assign rmw_active    = (state == RMW_WR) && !reset;

  // Classify the incoming request as illegal or misaligned.
  always_comb begin
    err = (bus.req_size == 2'd3);
    if (ALIGN_CHECK) begin
      if (bus.req_size == 2'd1 && bus.req_addr[0])          err = 1'b1;
      if (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00) err = 1'b1;
    end
  end

  // Drive the memory strobes, address and write word for the current cycle.
  always_comb begin
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Address    = '0;
    Write_data = '0;
    if (go) begin
      Address = aligned_addr;
      if (bus.req_write && bus.req_size == 2'd2) begin
        MemWrite   = 1'b1;
        Write_data = bus.req_wdata;
      end else begin
        MemRead = 1'b1;
      end
    end else if (rmw_active) begin
      MemWrite   = 1'b1;
      Address    = rmw_addr;
      Write_data = merge(rmw_word, rmw_wdata, rmw_lane, rmw_half);
    end
  end

  // Control FSM with registered response outputs and RMW capture registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      rmw_addr      <= '0;
      rmw_word      <= '0;
      rmw_wdata     <= '0;
      rmw_lane      <= '0;
      rmw_half      <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (err) begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
            end else if (!bus.req_write) begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_rdata <= extract(Read_data, bus.req_size, bus.req_addr[1:0],
                                       bus.req_signed);
            end else if (bus.req_size == 2'd2) begin
              bus.rsp_valid <= 1'b1;
            end else begin
              rmw_addr  <= aligned_addr;
              rmw_word  <= Read_data;
              rmw_wdata <= bus.req_wdata[15:0];
              rmw_lane  <= bus.req_addr[1:0];
              rmw_half  <= (bus.req_size == 2'd1);
              state     <= RMW_WR;
            end
          end
        end
        RMW_WR: begin
          bus.rsp_valid <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: one instance with alignment checking,
// one with forced alignment, each backed by a small word memory model.
module tb_load_store_unit;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_WIDTH(AW)) bus1 ();
  load_store_unit_if #(.ADDR_WIDTH(AW)) bus2 ();

  logic          rd1, wr1, rd2, wr2;
  logic [AW-1:0] addr1, addr2;
  logic [31:0]   wd1, wd2, rdat1, rdat2;
  logic [31:0]   mem1 [0:4095];
  logic [31:0]   mem2 [0:4095];

  load_store_unit #(.ADDR_WIDTH(AW), .ALIGN_CHECK(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave), .MemRead(rd1), .MemWrite(wr1),
    .Address(addr1), .Write_data(wd1), .Read_data(rdat1));

  load_store_unit #(.ADDR_WIDTH(AW), .ALIGN_CHECK(1'b0)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave), .MemRead(rd2), .MemWrite(wr2),
    .Address(addr2), .Write_data(wd2), .Read_data(rdat2));

  assign rdat1 = mem1[addr1[13:2]];
  assign rdat2 = mem2[addr2[13:2]];

  always @(posedge clk) begin
    if (wr1) mem1[addr1[13:2]] <= wd1;
    if (wr2) mem2[addr2[13:2]] <= wd2;
  end

  int total = 0;
  int bad   = 0;
  logic [32:0] q1[$];
  logic [32:0] q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitors: pop the oldest expectation whenever a response shows up.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset) begin
      check("mutex1", 32'(rd1 & wr1), 32'd0);
      if (bus1.rsp_valid) begin
        if (q1.size() == 0) check("unexpected_rsp1", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          check("rsp1_rdata", bus1.rsp_rdata, e[31:0]);
          check("rsp1_err", 32'(bus1.rsp_err), 32'(e[32]));
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset) begin
      check("mutex2", 32'(rd2 & wr2), 32'd0);
      if (bus2.rsp_valid) begin
        if (q2.size() == 0) check("unexpected_rsp2", 32'd1, 32'd0);
        else begin
          e = q2.pop_front();
          check("rsp2_rdata", bus2.rsp_rdata, e[31:0]);
          check("rsp2_err", 32'(bus2.rsp_err), 32'(e[32]));
        end
      end
    end
  end

  // Present one request when the unit is ready, check the same-cycle memory
  // strobes, and queue the expected response (unless push is clear).
  task automatic issue(input bit d2, input bit wr, input logic [1:0] size, input bit sgn,
                       input logic [31:0] a, input logic [31:0] wdata,
                       input bit exp_rd, input bit exp_wr, input bit push,
                       input logic [31:0] exp_rdata, input bit exp_err);
    int n = 0;
    @(negedge clk);
    while (!(d2 ? bus2.req_ready : bus1.req_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_timeout", 32'd1, 32'd0);
    if (d2) begin
      bus2.req_valid = 1'b1; bus2.req_write = wr; bus2.req_size = size;
      bus2.req_signed = sgn; bus2.req_addr = a; bus2.req_wdata = wdata;
    end else begin
      bus1.req_valid = 1'b1; bus1.req_write = wr; bus1.req_size = size;
      bus1.req_signed = sgn; bus1.req_addr = a; bus1.req_wdata = wdata;
    end
    #1;
    check("memread", 32'(d2 ? rd2 : rd1), 32'(exp_rd));
    check("memwrite", 32'(d2 ? wr2 : wr1), 32'(exp_wr));
    if (exp_rd || exp_wr)
      check("address", d2 ? addr2 : addr1, {a[31:2], 2'b00});
    if (exp_wr) check("write_data", d2 ? wd2 : wd1, wdata);
    if (push) begin
      if (d2) q2.push_back({exp_err, exp_rdata});
      else    q1.push_back({exp_err, exp_rdata});
    end
    @(posedge clk);
    #1;
    if (d2) bus2.req_valid = 1'b0;
    else    bus1.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem1[i] = '0;
      mem2[i] = '0;
    end
    mem1[2] = 32'h0000_0009;
    mem1[5] = 32'hFFFF_FFFF;
    mem2[2] = 32'h0000_0009;
    bus1.req_valid = 0; bus1.req_write = 0; bus1.req_size = 0; bus1.req_signed = 0;
    bus1.req_addr = '0; bus1.req_wdata = '0;
    bus2.req_valid = 0; bus2.req_write = 0; bus2.req_size = 0; bus2.req_signed = 0;
    bus2.req_addr = '0; bus2.req_wdata = '0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus1.rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(bus1.rsp_err), 32'd0);
    check("rst_memread", 32'(rd1), 32'd0);
    check("rst_memwrite", 32'(wr1), 32'd0);
    check("rst_address", addr1, 32'd0);
    check("rst_write_data", wd1, 32'd0);
    check("rst_ready", 32'(bus1.req_ready), 32'd1);

    // Loads of word 0x08 and sub-word lanes of 0x14.
    issue(0, 0, 2'd2, 0, 32'h08, 0, 1, 0, 1, 32'h0000_0009, 0);
    issue(0, 0, 2'd0, 1, 32'h14, 0, 1, 0, 1, 32'hFFFF_FFFF, 0);
    issue(0, 0, 2'd0, 0, 32'h14, 0, 1, 0, 1, 32'h0000_00FF, 0);
    issue(0, 0, 2'd1, 0, 32'h16, 0, 1, 0, 1, 32'h0000_FFFF, 0);
    issue(0, 0, 2'd1, 1, 32'h16, 0, 1, 0, 1, 32'hFFFF_FFFF, 0);

    // sb 0x5A to 0x15: read cycle, then merged write with req_ready low.
    issue(0, 1, 2'd0, 0, 32'h15, 32'h0000_005A, 1, 0, 1, 32'h0, 0);
    check("rmw_memwrite", 32'(wr1), 32'd1);
    check("rmw_memread", 32'(rd1), 32'd0);
    check("rmw_address", addr1, 32'h14);
    check("rmw_write_data", wd1, 32'hFFFF_5AFF);
    check("rmw_ready", 32'(bus1.req_ready), 32'd0);
    issue(0, 0, 2'd0, 1, 32'h15, 0, 1, 0, 1, 32'h0000_005A, 0);
    issue(0, 0, 2'd0, 1, 32'h14, 0, 1, 0, 1, 32'hFFFF_FFFF, 0);

    // Error cases: misaligned word/half and illegal size; no memory access.
    issue(0, 0, 2'd2, 0, 32'h0A, 0, 0, 0, 1, 32'h0, 1);
    issue(0, 1, 2'd1, 0, 32'h05, 32'h1234, 0, 0, 1, 32'h0, 1);
    issue(0, 0, 2'd3, 0, 32'h08, 0, 0, 0, 1, 32'h0, 1);

    // Back-to-back word store then load, then half store/loads on that word.
    issue(0, 1, 2'd2, 0, 32'h1000, 32'h1234_5678, 0, 1, 1, 32'h0, 0);
    issue(0, 0, 2'd2, 0, 32'h1000, 0, 1, 0, 1, 32'h1234_5678, 0);
    issue(0, 1, 2'd1, 0, 32'h1002, 32'h0000_BEEF, 1, 0, 1, 32'h0, 0);
    check("rmw_half_data", wd1, 32'hBEEF_5678);
    issue(0, 0, 2'd1, 1, 32'h1002, 0, 1, 0, 1, 32'hFFFF_BEEF, 0);
    issue(0, 0, 2'd1, 0, 32'h1000, 0, 1, 0, 1, 32'h0000_5678, 0);

    // Reset during RMW_WR of sb to 0x14: no write, no response.
    issue(0, 1, 2'd0, 0, 32'h14, 32'h0000_0033, 1, 0, 0, 32'h0, 0);
    reset = 1'b1;
    #1;
    check("rstrmw_memwrite", 32'(wr1), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    check("rstrmw_ready", 32'(bus1.req_ready), 32'd1);
    check("rstrmw_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    check("rstrmw_mem", mem1[5], 32'hFFFF_5AFF);
    issue(0, 0, 2'd2, 0, 32'h14, 0, 1, 0, 1, 32'hFFFF_5AFF, 0);

    // Forced alignment instance.
    issue(1, 0, 2'd2, 0, 32'h0A, 0, 1, 0, 1, 32'h0000_0009, 0);
    issue(1, 0, 2'd3, 0, 32'h08, 0, 0, 0, 1, 32'h0, 1);
    issue(1, 1, 2'd1, 0, 32'h05, 32'h0000_ABCD, 1, 0, 1, 32'h0, 0);
    issue(1, 0, 2'd2, 0, 32'h04, 0, 1, 0, 1, 32'h0000_ABCD, 0);

    repeat (5) @(negedge clk);
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q2_drained", 32'(q2.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
